rr_onehot_arbiter: RTL and testbench

RR_ONEHOT_ARBITER -- requirements
Module: rr_onehot_arbiter

---
 rtl/rr_onehot_arbiter.sv | 179 +++++++++++++++++
 tb/tb_rr_onehot_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_onehot_arbiter.sv
// -----------------------------------------------------------------------------
// rr_onehot_arbiter
//
// Round-robin arbiter producing a registered one-hot grant that drives the
// enable bus of a one-hot-enable muxer directly. A grant is held until the
// granted requester strobes done, drops its request, or the grant-timeout
// counter reaches tmo_val. Every release is followed by exactly one all-zero
// GAP cycle before the next arbitration. The releasing requester then has the
// lowest priority.
//
// Parameters:
//   NUM    - number of requesters (must match the downstream muxer)
//   TMO_W  - width of the grant-timeout counter
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   req      in   [NUM]   per-requester request level
//   done     in   [NUM]   per-requester one-cycle release strobe
//   tmo_val  in   [TMO_W] maximum grant length in cycles, 0 disables timeout
//   gnt      out  [NUM]   registered one-hot grant
//   gnt_idx  out  [IDX_W] index of the granted requester, 0 when none
//   busy     out          high in GRANT and GAP
//   tmo      out          one-cycle pulse when a grant is revoked by timeout
// -----------------------------------------------------------------------------
module rr_onehot_arbiter #(
    parameter int  NUM   = 4,
    parameter int  TMO_W = 8,
    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM-1:0]   req,
    input  logic [NUM-1:0]   done,
    input  logic [TMO_W-1:0] tmo_val,
    output logic [NUM-1:0]   gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             busy,
    output logic             tmo
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state_q;
    logic [NUM-1:0]   gnt_q;
    logic [IDX_W-1:0] gnt_idx_q;
    logic             busy_q;
    logic             tmo_q;
    logic [TMO_W-1:0] count_q;
    logic [IDX_W-1:0] ptr_q;

    logic             pick_found_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic             done_hit_s;
    logic             req_drop_s;
    logic             tmo_hit_s;
    logic             release_s;
    logic             tmo_only_s;
    logic [TMO_W-1:0] count_d;
    logic [IDX_W-1:0] ptr_d;

    // Round-robin scan of req beginning at ptr_q, wrapping modulo NUM.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        for (int i = 0; i < NUM; i++) begin
            int cand;
            cand = int'(ptr_q) + i;
            if (cand >= NUM) begin
                cand = cand - NUM;
            end else begin
                cand = cand;
            end
            if (!pick_found_s && req[cand]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = IDX_W'(cand);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Release terms for the currently granted index, saturating count and
    // the rotated pointer that makes the releasing requester lowest priority.
    always_comb begin
        done_hit_s = done[gnt_idx_q];
        req_drop_s = !req[gnt_idx_q];
        // Equality only: a tmo_val lowered below the running count never
        // releases retroactively, only the saturated count can match again.
        tmo_hit_s  = (tmo_val != {TMO_W{1'b0}}) && (count_q == tmo_val);
        release_s  = done_hit_s || req_drop_s || tmo_hit_s;
        tmo_only_s = tmo_hit_s && !done_hit_s && !req_drop_s;
        if (count_q == {TMO_W{1'b1}}) begin
            count_d = count_q;
        end else begin
            count_d = count_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end
        if (gnt_idx_q == IDX_W'(NUM - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = gnt_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end
    end

    // Arbitration FSM with all outputs registered; reset overrides every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            busy_q    <= 1'b0;
            tmo_q     <= 1'b0;
            count_q   <= '0;
            ptr_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tmo_q <= 1'b0;
                    if (pick_found_s) begin
                        state_q   <= S_GRANT;
                        gnt_q     <= NUM'(1'b1) << pick_idx_s;
                        gnt_idx_q <= pick_idx_s;
                        busy_q    <= 1'b1;
                        // The first granted cycle counts as 1.
                        count_q   <= TMO_W'(1'b1);
                    end else begin
                        state_q   <= S_IDLE;
                        gnt_q     <= '0;
                        gnt_idx_q <= '0;
                        busy_q    <= 1'b0;
                        count_q   <= '0;
                    end
                end
                S_GRANT: begin
                    if (release_s) begin
                        state_q   <= S_GAP;
                        gnt_q     <= '0;
                        gnt_idx_q <= '0;
                        busy_q    <= 1'b1;
                        tmo_q     <= tmo_only_s;
                        count_q   <= '0;
                        ptr_q     <= ptr_d;
                    end else begin
                        state_q   <= S_GRANT;
                        tmo_q     <= 1'b0;
                        count_q   <= count_d;
                    end
                end
                S_GAP: begin
                    state_q   <= S_IDLE;
                    gnt_q     <= '0;
                    gnt_idx_q <= '0;
                    busy_q    <= 1'b0;
                    tmo_q     <= 1'b0;
                    count_q   <= '0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    gnt_q     <= '0;
                    gnt_idx_q <= '0;
                    busy_q    <= 1'b0;
                    tmo_q     <= 1'b0;
                    count_q   <= '0;
                    ptr_q     <= '0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign busy    = busy_q;
    assign tmo     = tmo_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_onehot_arbiter
//
// Directed testbench for rr_onehot_arbiter (NUM=4, TMO_W=8). Inputs change
// 1 time unit after the rising edge; outputs are compared at the same point
// against hand-computed values packed as {gnt, gnt_idx, busy, tmo}. A negedge
// monitor checks grant one-hotness and gnt/gnt_idx consistency every cycle.
// -----------------------------------------------------------------------------
module tb_rr_onehot_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [7:0] tmo_val;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       tmo;

    int total;
    int bad;
    logic       mon_en;
    logic [3:0] mon_dec;
    logic [7:0] obs;

    rr_onehot_arbiter #(.NUM(4), .TMO_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .tmo_val (tmo_val),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy),
        .tmo     (tmo)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle invariants: at most one grant bit, gnt_idx matches gnt.
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if ($countones(gnt) > 1) begin
                bad++;
                $display("FAIL onehot: gnt=%b has %0d bits set, want at most 1", gnt, $countones(gnt));
            end
            mon_dec = (gnt == 4'b0000) ? 4'b0000 : (4'b0001 << gnt_idx);
            total++;
            if (gnt !== mon_dec || (gnt == 4'b0000 && gnt_idx !== 2'd0)) begin
                bad++;
                $display("FAIL idx_consistency: gnt=%b gnt_idx=%0d, want gnt=1<<gnt_idx or both zero", gnt, gnt_idx);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset with req held, then idle with no requests.
    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; done = 4'b0000; tmo_val = 8'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            mon_en = 1'b1;
            obs = {gnt, gnt_idx, busy, tmo};
            total++;
            if (obs !== 8'b0000_00_0_0) begin
                bad++;
                $display("FAIL reset_hold: got %b want %b", obs, 8'b0000_00_0_0);
            end
        end
        rst = 1'b0; req = 4'b0000;
        step();
        obs = {gnt, gnt_idx, busy, tmo};
        total++;
        if (obs !== 8'b0000_00_0_0) begin
            bad++;
            $display("FAIL idle_no_req: got %b want %b", obs, 8'b0000_00_0_0);
        end
    endtask

    // One-cycle request 1010 from reset: index 1 granted, then req-drop release.
    task automatic test_single();
        req = 4'b1010;
        step();
        obs = {gnt, gnt_idx, busy, tmo};
        total++;
        if (obs !== 8'b0010_01_1_0) begin
            bad++;
            $display("FAIL single_grant: got %b want %b", obs, 8'b0010_01_1_0);
        end
        req = 4'b0000;
        step();
        obs = {gnt, gnt_idx, busy, tmo};
        total++;
        if (obs !== 8'b0000_00_1_0) begin
            bad++;
            $display("FAIL single_gap: got %b want %b", obs, 8'b0000_00_1_0);
        end
        step();
        obs = {gnt, gnt_idx, busy, tmo};
        total++;
        if (obs !== 8'b0000_00_0_0) begin
            bad++;
            $display("FAIL single_idle: got %b want %b", obs, 8'b0000_00_0_0);
        end
    endtask

    // All requesting, done every 5 cycles: order 0,1,2,3,0 with GAP between.
    task automatic test_round_robin();
        logic [3:0] one;
        logic [1:0] idx;
        rst = 1'b1;
        step();
        rst = 1'b0; req = 4'b1111; tmo_val = 8'd0;
        step();
        for (int k = 0; k < 5; k++) begin
            idx = 2'(k % 4);
            one = 4'b0001 << idx;
            for (int c = 0; c < 3; c++) begin
                obs = {gnt, gnt_idx, busy, tmo};
                total++;
                if (obs !== {one, idx, 1'b1, 1'b0}) begin
                    bad++;
                    $display("FAIL rr_grant k=%0d c=%0d: got %b want %b", k, c, obs, {one, idx, 1'b1, 1'b0});
                end
                if (c < 2) step();
            end
            done = one;
            step();
            done = 4'b0000;
            obs = {gnt, gnt_idx, busy, tmo};
            total++;
            if (obs !== 8'b0000_00_1_0) begin
                bad++;
                $display("FAIL rr_gap k=%0d: got %b want %b", k, obs, 8'b0000_00_1_0);
            end
            if (k == 4) req = 4'b0000;
            step();
            obs = {gnt, gnt_idx, busy, tmo};
            total++;
            if (obs !== 8'b0000_00_0_0) begin
                bad++;
                $display("FAIL rr_idle k=%0d: got %b want %b", k, obs, 8'b0000_00_0_0);
            end
            if (k < 4) step();
        end
    endtask

    // Timeout release with tmo pulse, regrant, then done on the limit cycle.
    task automatic test_timeout();
        req = 4'b0100; tmo_val = 8'd3;
        for (int c = 0; c < 3; c++) begin
            step();
            obs = {gnt, gnt_idx, busy, tmo};
            total++;
            if (obs !== 8'b0100_10_1_0) begin
                bad++;
                $display("FAIL tmo_grant c=%0d: got %b want %b", c, obs, 8'b0100_10_1_0);
            end
        end
        step();
        obs = {gnt, gnt_idx, busy, tmo};
        total++;
        if (obs !== 8'b0000_00_1_1) begin
            bad++;
            $display("FAIL tmo_gap: got %b want %b", obs, 8'b0000_00_1_1);
        end
        step();
        obs = {gnt, gnt_idx, busy, tmo};
        total++;
        if (obs !== 8'b0000_00_0_0) begin
            bad++;
            $display("FAIL tmo_idle: got %b want %b", obs, 8'b0000_00_0_0);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            obs = {gnt, gnt_idx, busy, tmo};
            total++;
            if (obs !== 8'b0100_10_1_0) begin
                bad++;
                $display("FAIL tmo_regrant c=%0d: got %b want %b", c, obs, 8'b0100_10_1_0);
            end
        end
        done = 4'b0100;
        step();
        done = 4'b0000; req = 4'b0000;
        obs = {gnt, gnt_idx, busy, tmo};
        total++;
        if (obs !== 8'b0000_00_1_0) begin
            bad++;
            $display("FAIL done_at_limit_gap: got %b want %b", obs, 8'b0000_00_1_0);
        end
        step();
        obs = {gnt, gnt_idx, busy, tmo};
        total++;
        if (obs !== 8'b0000_00_0_0) begin
            bad++;
            $display("FAIL done_at_limit_idle: got %b want %b", obs, 8'b0000_00_0_0);
        end
    endtask

    // tmo_val changed mid-grant: lowered below count never fires, raised fires.
    task automatic test_tmo_change();
        req = 4'b0001; tmo_val = 8'd0;
        for (int c = 1; c <= 16; c++) begin
            step();
            obs = {gnt, gnt_idx, busy, tmo};
            total++;
            if (obs !== 8'b0001_00_1_0) begin
                bad++;
                $display("FAIL tmochg_grant c=%0d: got %b want %b", c, obs, 8'b0001_00_1_0);
            end
            if (c == 4) tmo_val = 8'd2;
            if (c == 14) tmo_val = 8'd16;
        end
        step();
        req = 4'b0000;
        obs = {gnt, gnt_idx, busy, tmo};
        total++;
        if (obs !== 8'b0000_00_1_1) begin
            bad++;
            $display("FAIL tmochg_gap: got %b want %b", obs, 8'b0000_00_1_1);
        end
        step();
    endtask

    // Count saturates at 255: setting tmo_val=255 after 300 cycles releases.
    task automatic test_saturation();
        req = 4'b0001; tmo_val = 8'd0;
        step();
        repeat (299) step();
        obs = {gnt, gnt_idx, busy, tmo};
        total++;
        if (obs !== 8'b0001_00_1_0) begin
            bad++;
            $display("FAIL sat_grant: got %b want %b", obs, 8'b0001_00_1_0);
        end
        tmo_val = 8'd255;
        step();
        req = 4'b0000; tmo_val = 8'd0;
        obs = {gnt, gnt_idx, busy, tmo};
        total++;
        if (obs !== 8'b0000_00_1_1) begin
            bad++;
            $display("FAIL sat_gap: got %b want %b", obs, 8'b0000_00_1_1);
        end
        step();
    endtask

    // Reset on 2nd cycle of grant to index 3 clears gnt and ptr; no GAP.
    task automatic test_reset_mid_grant();
        req = 4'b1000;
        for (int c = 0; c < 2; c++) begin
            step();
            obs = {gnt, gnt_idx, busy, tmo};
            total++;
            if (obs !== 8'b1000_11_1_0) begin
                bad++;
                $display("FAIL rstmid_grant c=%0d: got %b want %b", c, obs, 8'b1000_11_1_0);
            end
        end
        rst = 1'b1;
        step();
        obs = {gnt, gnt_idx, busy, tmo};
        total++;
        if (obs !== 8'b0000_00_0_0) begin
            bad++;
            $display("FAIL rstmid_clear: got %b want %b", obs, 8'b0000_00_0_0);
        end
        rst = 1'b0; req = 4'b1001;
        step();
        obs = {gnt, gnt_idx, busy, tmo};
        total++;
        if (obs !== 8'b0001_00_1_0) begin
            bad++;
            $display("FAIL rstmid_ptr0: got %b want %b", obs, 8'b0001_00_1_0);
        end
    endtask

    // Non-granted done/req activity is ignored while index 0 holds the grant.
    task automatic test_ignore_others();
        req = 4'b1111; done = 4'b1110;
        step();
        obs = {gnt, gnt_idx, busy, tmo};
        total++;
        if (obs !== 8'b0001_00_1_0) begin
            bad++;
            $display("FAIL ignore_done: got %b want %b", obs, 8'b0001_00_1_0);
        end
        done = 4'b0000; req = 4'b0011;
        step();
        obs = {gnt, gnt_idx, busy, tmo};
        total++;
        if (obs !== 8'b0001_00_1_0) begin
            bad++;
            $display("FAIL ignore_req: got %b want %b", obs, 8'b0001_00_1_0);
        end
        done = 4'b0001; req = 4'b0000;
        step();
        done = 4'b0000;
        obs = {gnt, gnt_idx, busy, tmo};
        total++;
        if (obs !== 8'b0000_00_1_0) begin
            bad++;
            $display("FAIL ignore_release_gap: got %b want %b", obs, 8'b0000_00_1_0);
        end
        step();
    endtask

    initial begin
        total = 0; bad = 0; mon_en = 1'b0;
        rst = 1'b1; req = 4'b0000; done = 4'b0000; tmo_val = 8'd0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_tmo_change();
        test_saturation();
        test_reset_mid_grant();
        test_ignore_others();
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
